// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and sizing helpers for the instruction fetch front end
//
// Purpose: default geometry of the fetch front end, the queue entry layout
//          and the occupancy-counter width helper used by the top level.
// Ports:   none (package).

package fetch_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;

  // Occupancy counter must represent 0..DEPTH inclusive, hence the extra bit.
  localparam int CNT_W = $clog2(DEF_DEPTH) + 1;

  // One prefetched byte together with the address it came from.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } fetch_entry_t;

  // Counter width for an arbitrary queue depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with flush, occupancy count and registered head
//
// Purpose: circular buffer of DEPTH entries (DEPTH a power of two, >= 2).
// Ports:
//   clk      in   clock, all state on posedge
//   rst      in   asynchronous active-high reset
//   flush_i  in   drop all entries; wins over push/pop in the same cycle
//   push_i   in   write data_i at the tail
//   data_i   in   WIDTH  entry to write
//   pop_i    in   remove the head entry (ignored when empty)
//   head_o   out  WIDTH  current head entry (stale contents when empty)
//   count_o  out  number of stored entries, 0..DEPTH
//   empty_o  out  count_o == 0

module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic full;
  logic do_push;
  logic do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A pop frees a slot in the same cycle, so push into a full queue is fine then.
  assign do_push = push_i & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - prefetching instruction fetch front end with redirect
//
// Purpose: autonomously fetches sequential program bytes into a prefetch
//          queue and hands them to the core over a valid/ready handshake;
//          a jump flushes the queue and restarts fetching at the target.
// Ports:
//   clk          in   clock, all state on posedge
//   rst          in   asynchronous active-high reset
//   mem_rd       out  program-memory read strobe
//   mem_addr     out  ADDR_W  read address (current fetch pointer)
//   mem_data     in   DATA_W  read data, valid one cycle after mem_rd
//   op_code      out  DATA_W  queue-head opcode, 0 when empty
//   op_pc        out  ADDR_W  address of op_code, 0 when empty
//   op_valid     out  queue non-empty
//   op_ready     in   core takes the head this cycle
//   jump         in   single-cycle redirect strobe
//   jump_target  in   ADDR_W  new fetch address

module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] op_code,
  output logic [ADDR_W-1:0] op_pc,
  output logic              op_valid,
  input  logic              op_ready,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target
);

  localparam int Q_CNT_W = cnt_width(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  logic [ADDR_W-1:0] fpc_q;
  logic [ADDR_W-1:0] fpc_d;
  logic              inflight_q;
  logic              inflight_d;

  logic               q_empty;
  logic [Q_CNT_W-1:0] q_count;
  entry_t             q_head;
  entry_t             q_push_entry;

  logic             pop;
  logic             push;
  logic             issue;
  logic [Q_CNT_W:0] credit_used;

  assign op_valid = ~q_empty;
  assign pop      = op_valid & op_ready & ~jump;

  // Slots already owed: stored entries plus the read still returning,
  // less the entry leaving this cycle. One extra bit so DEPTH+1 cannot wrap.
  assign credit_used = {1'b0, q_count}
                     + {{Q_CNT_W{1'b0}}, inflight_q}
                     - {{Q_CNT_W{1'b0}}, pop};

  // The ~rst term keeps the strobe low while reset is held, since the
  // credit check alone would already allow a read from the reset state.
  assign issue = ~rst & ~jump & (credit_used < (Q_CNT_W + 1)'(DEPTH));

  // A jump in the issue cycle prevents the issue altogether, so only a jump
  // in the return cycle needs to kill the push.
  assign push = inflight_q & ~jump;

  // During the return cycle fpc has advanced exactly once past the read
  // address (any jump in between would have suppressed this push).
  assign q_push_entry.addr = fpc_q - 1'b1;
  assign q_push_entry.data = mem_data;

  always_comb begin
    fpc_d      = fpc_q;
    inflight_d = issue;
    if (jump) begin
      fpc_d = jump_target;
    end else if (issue) begin
      fpc_d = fpc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_q      <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      fpc_q      <= fpc_d;
      inflight_q <= inflight_d;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .flush_i (jump),
    .push_i  (push),
    .data_i  (q_push_entry),
    .pop_i   (pop),
    .head_o  (q_head),
    .count_o (q_count),
    .empty_o (q_empty)
  );

  assign mem_rd   = issue;
  assign mem_addr = fpc_q;
  assign op_code  = op_valid ? q_head.data : '0;
  assign op_pc    = op_valid ? q_head.addr : '0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - directed bench for instr_fetch_queue at several geometries

module tb_instr_fetch_queue;

  localparam int N = 4;

  logic       clk;
  logic       rst;
  logic       op_ready;
  logic       jump;
  logic [7:0] jump_target;

  logic       mem_rd_a   [N];
  logic [7:0] mem_addr_a [N];
  logic [7:0] mem_data_a [N];
  logic [7:0] op_code_a  [N];
  logic [7:0] op_pc_a    [N];
  logic       op_valid_a [N];

  int         dep_of [N];
  logic [7:0] rp_of  [N];
  int         reads  [N];

  int checks = 0;
  int errors = 0;

  // Instance 0: DEPTH 4, RESET_PC 00; 1: DEPTH 4, RESET_PC FE; 2: DEPTH 2; 3: DEPTH 8.
  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int         D  = (g == 2) ? 2 : ((g == 3) ? 8 : 4);
    localparam logic [7:0] RP = (g == 1) ? 8'hFE : 8'h00;
    instr_fetch_queue #(
      .ADDR_W   (8),
      .DATA_W   (8),
      .DEPTH    (D),
      .RESET_PC (RP)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .mem_rd      (mem_rd_a[g]),
      .mem_addr    (mem_addr_a[g]),
      .mem_data    (mem_data_a[g]),
      .op_code     (op_code_a[g]),
      .op_pc       (op_pc_a[g]),
      .op_valid    (op_valid_a[g]),
      .op_ready    (op_ready),
      .jump        (jump),
      .jump_target (jump_target)
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Program memory: mem[a] = a ^ A5, one-cycle read latency, X when not read.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      mem_data_a[i] <= mem_rd_a[i] ? (mem_addr_a[i] ^ 8'hA5) : 8'hxx;
    end
  end

  task automatic chk(input string tag, input int g, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, g, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int g = 0; g < N; g++) begin
      chk({tag, "_mem_rd"},   g, 8'(mem_rd_a[g]),   8'h00);
      chk({tag, "_mem_addr"}, g, mem_addr_a[g],     rp_of[g]);
      chk({tag, "_op_valid"}, g, 8'(op_valid_a[g]), 8'h00);
      chk({tag, "_op_code"},  g, op_code_a[g],      8'h00);
      chk({tag, "_op_pc"},    g, op_pc_a[g],        8'h00);
    end
  endtask

  // Returns at the start of cycle 0 (first cycle with rst low).
  task automatic do_reset(input logic rdy);
    rst      = 1'b1;
    op_ready = rdy;
    jump     = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // Cycle c counts from the first issue at base; reads every cycle,
  // opcodes from cycle 2 on, one per cycle with no gaps.
  task automatic expect_stream(input bit from_rp, input logic [7:0] tgt,
                               input int start_c, input int n, input string tag);
    logic [7:0] b;
    logic [7:0] pc;
    for (int c = start_c; c < start_c + n; c++) begin
      @(negedge clk);
      for (int g = 0; g < N; g++) begin
        b = from_rp ? rp_of[g] : tgt;
        chk({tag, "_mem_rd"},   g, 8'(mem_rd_a[g]), 8'h01);
        chk({tag, "_mem_addr"}, g, mem_addr_a[g],   b + 8'(c));
        if (c >= 2) begin
          pc = b + 8'(c - 2);
          chk({tag, "_op_valid"}, g, 8'(op_valid_a[g]), 8'h01);
          chk({tag, "_op_pc"},    g, op_pc_a[g],        pc);
          chk({tag, "_op_code"},  g, op_code_a[g],      pc ^ 8'hA5);
        end else begin
          chk({tag, "_op_valid"}, g, 8'(op_valid_a[g]), 8'h00);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    dep_of      = '{4, 4, 2, 8};
    rp_of       = '{8'h00, 8'hFE, 8'h00, 8'h00};
    rst         = 1'b1;
    op_ready    = 1'b1;
    jump        = 1'b0;
    jump_target = 8'h00;
    #1;

    // 1 / 4: streaming from reset; instance 1 covers the FE,FF,00,01 wrap.
    do_reset(1'b1);
    expect_stream(1'b1, 8'h00, 0, 10, "t1");

    // 2: core stalled -> exactly DEPTH reads, then in-order drain and stream.
    do_reset(1'b0);
    for (int g = 0; g < N; g++) reads[g] = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      for (int g = 0; g < N; g++) if (mem_rd_a[g] === 1'b1) reads[g]++;
      next_cycle();
    end
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      chk("t2_reads",    g, 8'(reads[g]),      8'(dep_of[g]));
      chk("t2_idle_rd",  g, 8'(mem_rd_a[g]),   8'h00);
      chk("t2_full_vld", g, 8'(op_valid_a[g]), 8'h01);
      chk("t2_head_pc",  g, op_pc_a[g],        rp_of[g]);
    end
    next_cycle();
    op_ready = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      for (int g = 0; g < N; g++) begin
        chk("t2_op_valid", g, 8'(op_valid_a[g]), 8'h01);
        chk("t2_op_pc",    g, op_pc_a[g],        rp_of[g] + 8'(j));
        chk("t2_op_code",  g, op_code_a[g],      (rp_of[g] + 8'(j)) ^ 8'hA5);
      end
      next_cycle();
    end

    // 3: jump to 40 with a (nearly) full queue and a read in flight.
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) next_cycle();
    op_ready = 1'b1;
    next_cycle();
    jump        = 1'b1;
    jump_target = 8'h40;
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      chk("t3_jmp_rd",  g, 8'(mem_rd_a[g]),   8'h00);
      chk("t3_jmp_vld", g, 8'(op_valid_a[g]), 8'h01);
      chk("t3_jmp_pc",  g, op_pc_a[g],        rp_of[g] + 8'h01);
    end
    next_cycle();
    jump = 1'b0;
    expect_stream(1'b0, 8'h40, 0, 8, "t3");

    // 5: back-to-back jumps 10 then 20; the last one wins.
    jump        = 1'b1;
    jump_target = 8'h10;
    @(negedge clk);
    for (int g = 0; g < N; g++) chk("t5_j1_rd", g, 8'(mem_rd_a[g]), 8'h00);
    next_cycle();
    jump_target = 8'h20;
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      chk("t5_j2_rd",  g, 8'(mem_rd_a[g]),   8'h00);
      chk("t5_j2_vld", g, 8'(op_valid_a[g]), 8'h00);
    end
    next_cycle();
    jump = 1'b0;
    expect_stream(1'b0, 8'h20, 0, 8, "t5");

    // 6: reset pulse between edges mid-stream.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs("t6_rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int g = 0; g < N; g++) begin
      chk("t6_c0_rd",   g, 8'(mem_rd_a[g]),   8'h01);
      chk("t6_c0_addr", g, mem_addr_a[g],     rp_of[g]);
      chk("t6_c0_vld",  g, 8'(op_valid_a[g]), 8'h00);
    end
    next_cycle();
    expect_stream(1'b1, 8'h00, 1, 8, "t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
